// File: rtl/ifid_branch_unit_if.sv
// rtl/ifid_branch_unit_if.sv - fetch / IF-ID / branch-resolve signal bundle
interface ifid_branch_unit_if;
  logic [31:0] IF_instr;
  logic        PCWrite;
  logic        IFID_write;
  logic        ID_flush;
  logic        forward1;
  logic        forward2;
  logic        ID_branch;
  logic        ID_bne;
  logic [31:0] ID_readData1;
  logic [31:0] ID_readData2;
  logic [31:0] EXMEM_aluResult;
  logic [31:0] IF_pc;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pcPlus4;
  logic [4:0]  ID_regRs;
  logic [4:0]  ID_regRt;
  logic        ID_taken;
  logic        ID_bubble;

  // Hazard unit / pipeline side: drives controls and operands, observes fetch state.
  modport master (
    output IF_instr, PCWrite, IFID_write, ID_flush, forward1, forward2,
           ID_branch, ID_bne, ID_readData1, ID_readData2, EXMEM_aluResult,
    input  IF_pc, IFID_instr, IFID_pcPlus4, ID_regRs, ID_regRt, ID_taken, ID_bubble
  );

  // Branch unit side: owns PC and IF/ID, resolves branches.
  modport slave (
    input  IF_instr, PCWrite, IFID_write, ID_flush, forward1, forward2,
           ID_branch, ID_bne, ID_readData1, ID_readData2, EXMEM_aluResult,
    output IF_pc, IFID_instr, IFID_pcPlus4, ID_regRs, ID_regRt, ID_taken, ID_bubble
  );
endinterface

// File: rtl/ifid_branch_unit.sv
// rtl/ifid_branch_unit.sv - PC, IF/ID register and ID-stage beq/bne resolution
module ifid_branch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ifid_branch_unit_if.slave  bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   taken_cnt
);

  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pcp4_q;
  logic [31:0] pc_plus4;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] br_target;
  logic        taken;

  // Operand select, branch condition and target; a stall or flush suppresses resolution.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    op_a      = bus.forward1 ? bus.EXMEM_aluResult : bus.ID_readData1;
    op_b      = bus.forward2 ? bus.EXMEM_aluResult : bus.ID_readData2;
    br_target = ifid_pcp4_q + {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};
    taken     = bus.ID_branch & bus.PCWrite & ~bus.ID_flush
              & ((op_a == op_b) ^ bus.ID_bne);
  end

  assign bus.IF_pc        = pc_q;
  assign bus.IFID_instr   = ifid_instr_q;
  assign bus.IFID_pcPlus4 = ifid_pcp4_q;
  assign bus.ID_regRs     = ifid_instr_q[25:21];
  assign bus.ID_regRt     = ifid_instr_q[20:16];
  assign bus.ID_taken     = taken;
  assign bus.ID_bubble    = bus.ID_flush | ~bus.IFID_write;

  // PC: redirect on taken branch, otherwise advance unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (taken) begin
      pc_q <= br_target;
    end else if (bus.PCWrite) begin
      pc_q <= pc_plus4;
    end
  end

  // IF/ID: a taken branch squashes the wrong-path fetch even when IF/ID is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pcp4_q  <= 32'd0;
    end else if (taken) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pcp4_q  <= 32'd0;
    end else if (bus.IFID_write) begin
      ifid_instr_q <= bus.IF_instr;
      ifid_pcp4_q  <= pc_plus4;
    end
  end

  // Saturating performance counters; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (!bus.PCWrite && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (taken && taken_cnt != '1) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifid_branch_unit.sv
// tb/tb_ifid_branch_unit.sv - directed self-checking bench for ifid_branch_unit
module tb_ifid_branch_unit;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] taken_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  localparam logic [31:0] I0   = 32'h0123_4567;
  localparam logic [31:0] I1   = 32'h0AAA_0001;
  localparam logic [31:0] I2   = 32'h0BBB_0002;
  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] BNE  = 32'h1464_FFFF;
  localparam logic [31:0] BEQ2 = 32'h1022_0002;
  localparam logic [31:0] WRG  = 32'hDEAD_BEEF;

  ifid_branch_unit_if bus ();

  ifid_branch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .stall_cnt(stall_cnt),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    bus.IF_instr = I0;
    bus.PCWrite = 1'b1;
    bus.IFID_write = 1'b1;
    bus.ID_flush = 1'b0;
    bus.forward1 = 1'b0;
    bus.forward2 = 1'b0;
    bus.ID_branch = 1'b0;
    bus.ID_bne = 1'b0;
    bus.ID_readData1 = 32'd0;
    bus.ID_readData2 = 32'd0;
    bus.EXMEM_aluResult = 32'd0;

    // Reset state
    #3;
    chk("rst_pc", bus.IF_pc, 32'h0);
    chk("rst_instr", bus.IFID_instr, 32'h0);
    chk("rst_pcp4", bus.IFID_pcPlus4, 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_taken", 32'(taken_cnt), 32'd0);
    #9 rst_n = 1'b1;
    #1 chk("seq_pc0", bus.IF_pc, 32'h0);

    // 1: sequential fetch
    tick();
    chk("seq_pc4", bus.IF_pc, 32'h4);
    chk("seq_pcp4_4", bus.IFID_pcPlus4, 32'h4);
    chk("seq_instr0", bus.IFID_instr, I0);
    chk("seq_rs", 32'(bus.ID_regRs), 32'd9);
    chk("seq_rt", 32'(bus.ID_regRt), 32'd3);
    bus.IF_instr = I1;
    tick();
    chk("seq_pc8", bus.IF_pc, 32'h8);
    chk("seq_pcp4_8", bus.IFID_pcPlus4, 32'h8);
    tick();
    chk("seq_pc12", bus.IF_pc, 32'hC);
    chk("seq_pcp4_12", bus.IFID_pcPlus4, 32'hC);

    // 2: stall with flush for two cycles
    bus.PCWrite = 1'b0;
    bus.IFID_write = 1'b0;
    bus.ID_flush = 1'b1;
    #1;
    chk("stall_bubble", 32'(bus.ID_bubble), 32'd1);
    chk("stall_notaken", 32'(bus.ID_taken), 32'd0);
    tick();
    chk("stall_pc_a", bus.IF_pc, 32'hC);
    chk("stall_cnt1", 32'(stall_cnt), 32'd1);
    tick();
    chk("stall_pc_b", bus.IF_pc, 32'hC);
    chk("stall_pcp4", bus.IFID_pcPlus4, 32'hC);
    chk("stall_instr", bus.IFID_instr, I1);
    chk("stall_cnt2", 32'(stall_cnt), 32'd2);

    // 3: taken beq with forwarded operand A
    bus.PCWrite = 1'b1;
    bus.IFID_write = 1'b1;
    bus.ID_flush = 1'b0;
    bus.IF_instr = I2;
    #1 chk("bubble_off", 32'(bus.ID_bubble), 32'd0);
    tick();
    bus.IF_instr = BEQ;
    tick();
    chk("beq_pcp4", bus.IFID_pcPlus4, 32'h14);
    bus.ID_branch = 1'b1;
    bus.ID_bne = 1'b0;
    bus.forward1 = 1'b1;
    bus.EXMEM_aluResult = 32'd7;
    bus.ID_readData1 = 32'd99;
    bus.ID_readData2 = 32'd7;
    bus.IF_instr = WRG;
    #1;
    chk("beq_taken", 32'(bus.ID_taken), 32'd1);
    tick();
    chk("beq_pc", bus.IF_pc, 32'h20);
    chk("beq_squash", bus.IFID_instr, 32'h0);
    chk("beq_squash_pcp4", bus.IFID_pcPlus4, 32'h0);
    chk("beq_tcnt", 32'(taken_cnt), 32'd1);
    bus.ID_branch = 1'b0;
    bus.forward1 = 1'b0;
    #1 chk("beq_nobranch", 32'(bus.ID_taken), 32'd0);

    // 4: bne not taken on equal, taken backwards on unequal
    bus.IF_instr = BNE;
    tick();
    bus.ID_branch = 1'b1;
    bus.ID_bne = 1'b1;
    bus.ID_readData1 = 32'd5;
    bus.ID_readData2 = 32'd5;
    #1 chk("bne_eq_notaken", 32'(bus.ID_taken), 32'd0);
    tick();
    chk("bne_seq_pc", bus.IF_pc, 32'h28);
    chk("bne_seq_pcp4", bus.IFID_pcPlus4, 32'h28);
    chk("bne_seq_tcnt", 32'(taken_cnt), 32'd1);
    bus.ID_readData2 = 32'd6;
    bus.IF_instr = WRG;
    #1 chk("bne_ne_taken", 32'(bus.ID_taken), 32'd1);
    tick();
    chk("bne_back_pc", bus.IF_pc, 32'h24);
    chk("bne_squash", bus.IFID_instr, 32'h0);
    chk("bne_tcnt", 32'(taken_cnt), 32'd2);

    // 5: branch held by stall, resolves once released
    bus.ID_branch = 1'b0;
    bus.ID_bne = 1'b0;
    bus.IF_instr = BEQ2;
    tick();
    chk("hold_pcp4", bus.IFID_pcPlus4, 32'h28);
    bus.ID_branch = 1'b1;
    bus.ID_readData1 = 32'd9;
    bus.ID_readData2 = 32'd9;
    bus.PCWrite = 1'b0;
    bus.IFID_write = 1'b0;
    bus.IF_instr = WRG;
    #1;
    chk("hold_notaken", 32'(bus.ID_taken), 32'd0);
    chk("hold_bubble", 32'(bus.ID_bubble), 32'd1);
    tick();
    chk("hold_pc", bus.IF_pc, 32'h28);
    chk("hold_instr", bus.IFID_instr, BEQ2);
    chk("hold_stall3", 32'(stall_cnt), 32'd3);
    bus.PCWrite = 1'b1;
    bus.IFID_write = 1'b1;
    #1 chk("rel_taken", 32'(bus.ID_taken), 32'd1);
    tick();
    chk("rel_pc", bus.IF_pc, 32'h30);
    chk("rel_tcnt", 32'(taken_cnt), 32'd3);

    // 6: saturation, clear, asynchronous reset mid-stall
    bus.ID_branch = 1'b0;
    bus.PCWrite = 1'b0;
    bus.IFID_write = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd3);
    chk("sat_pc", bus.IF_pc, 32'h30);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_stall", 32'(stall_cnt), 32'd0);
    chk("clr_taken", 32'(taken_cnt), 32'd0);
    tick();
    tick();
    chk("post_clr_stall", 32'(stall_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.IF_pc, 32'h0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_instr", bus.IFID_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
